// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: accepts one load/store from the memory stage and serialises it
// into 1..4 single-byte beats on a byte-wide data memory port. Load bytes return with
// one cycle of latency and are assembled little-endian, then sign- or zero-extended.
// Illegal requests are answered with an error response and never touch memory.
module lsu_mem_initiator #(
    parameter int ADDR_W      = 7,
    parameter int MEM_BYTES   = 128,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    // Access-size encoding on req_ctrl
    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Captured request fields; the core may change its inputs after acceptance
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [2:0]          r_ctrl;
    logic [1:0]          r_last;     // N-1
    logic                r_err;

    logic [1:0]          r_cnt;      // current beat index
    logic                r_rd_pend;  // a read strobe was issued last cycle
    logic [1:0]          r_rd_idx;   // beat index of that read
    logic [31:0]         r_result;   // raw little-endian load bytes
    logic                r_alive;    // low while in reset and for the release cycle

    logic                w_accept;
    logic [1:0]          w_size_m1;
    logic                w_bad_ctrl;
    logic                w_bad_store;
    logic                w_misalign;
    logic [32:0]         w_end_addr;
    logic                w_oob;
    logic                w_req_err;
    logic [31:0]         w_ext;

    assign w_accept = req_valid & req_ready;

    // Decode size of the incoming request and every reason to reject it
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_size_m1   = 2'd0;
        w_bad_ctrl  = 1'b0;
        unique case (req_ctrl)
            CTRL_B, CTRL_BU: w_size_m1 = 2'd0;
            CTRL_H, CTRL_HU: w_size_m1 = 2'd1;
            CTRL_W:          w_size_m1 = 2'd3;
            default:         w_bad_ctrl = 1'b1;
        endcase
        w_bad_store = req_we & req_ctrl[2];
        w_misalign  = CHECK_ALIGN &&
                      (((w_size_m1 == 2'd1) && req_addr[0]) ||
                       ((w_size_m1 == 2'd3) && (req_addr[1:0] != 2'b00)));
        // 33-bit sum so that high address bits and wrap-around both count as out of range
        w_end_addr  = {1'b0, req_addr} + {31'd0, w_size_m1};
        w_oob       = w_end_addr > 33'(MEM_BYTES - 1);
        w_req_err   = w_bad_ctrl | w_bad_store | w_misalign | w_oob;
    end

    // Sign/zero extension of the assembled load bytes
    always_comb begin
        w_ext = r_result;
        unique case (r_ctrl)
            CTRL_B:  w_ext = {{24{r_result[7]}}, r_result[7:0]};
            CTRL_H:  w_ext = {{16{r_result[15]}}, r_result[15:0]};
            CTRL_BU: w_ext = {24'd0, r_result[7:0]};
            CTRL_HU: w_ext = {16'd0, r_result[15:0]};
            default: w_ext = r_result;
        endcase
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and all state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 8'd0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = r_alive;
                if (w_accept) begin
                    w_next_state = w_req_err ? S_RESP : S_XFER;
                end
            end
            S_XFER: begin
                mem_addr = r_base + ADDR_W'(r_cnt);
                if (r_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
                end else begin
                    mem_re    = 1'b1;
                end
                if (r_cnt == r_last) begin
                    w_next_state = r_we ? S_RESP : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                rsp_valid    = 1'b1;
                rsp_err      = r_err;
                rsp_rdata    = (r_err || r_we) ? 32'd0 : w_ext;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture request fields at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base  <= '0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_ctrl  <= 3'd0;
            r_last  <= 2'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_base  <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
            r_we    <= req_we;
            r_ctrl  <= req_ctrl;
            r_last  <= w_size_m1;
            r_err   <= w_req_err;
        end
    end

    // Beat counter: steps once per XFER cycle, back to 0 after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
        end else if (r_state == S_XFER) begin
            r_cnt <= (r_cnt == r_last) ? 2'd0 : r_cnt + 2'd1;
        end
    end

    // Read return path: byte from a read strobe arrives one cycle later and lands at its lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_idx  <= 2'd0;
            r_result  <= 32'd0;
        end else begin
            r_rd_pend <= mem_re;
            r_rd_idx  <= r_cnt;
            if (w_accept) begin
                r_result <= 32'd0;
            end else if (r_rd_pend) begin
                r_result[{r_rd_idx, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

    // Hold req_ready low while reset is asserted; raise it on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 128-byte memory model of 1-cycle read latency.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    lsu_mem_initiator #(.ADDR_W(7), .MEM_BYTES(128), .CHECK_ALIGN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_acc = 0;
    int n_strobe = 0;
    int n_rsp = 0;
    int viol = 0;

    logic [7:0] mem [128];
    int         wr_cyc  [$];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: byte writes on the edge, registered read data
    always @(posedge clk) begin
        cyc++;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : 8'h00;
    end

    // Port monitor sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back({1'b0, mem_addr});
            wr_data.push_back(mem_wdata);
        end
        if (mem_we || mem_re) n_strobe++;
        if (rsp_valid) n_rsp++;
        if (mem_we && mem_re) viol++;
        if (!mem_we && !mem_re && (mem_addr != 7'd0 || mem_wdata != 8'd0)) viol++;
    end

    // Present a request, wait for acceptance, return at the negedge of cycle t+1
    task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                             input logic we, input logic [2:0] c);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_we = we; req_ctrl = c;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    endtask

    // Wait for the response and check latency, error flag and data
    task automatic wait_rsp(input string tag, input int exp_lat,
                            input logic exp_err, input logic [31:0] exp_data);
        while (!rsp_valid && (cyc - t_acc) < 40) @(negedge clk);
        check({tag, "_lat"},   32'(cyc - t_acc), 32'(exp_lat));
        check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, rsp_rdata, exp_data);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [2:0] c, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_data);
        start_req(a, d, we, c);
        wait_rsp(tag, exp_lat, exp_err, exp_data);
    endtask

    // Error request: error response at t+1 and no strobe anywhere
    task automatic run_err(input string tag, input logic [31:0] a,
                           input logic we, input logic [2:0] c);
        int s0;
        s0 = n_strobe;
        run(tag, a, 32'hCAFE_F00D, we, c, 1, 1'b1, 32'd0);
        @(negedge clk);
        check({tag, "_nostrobe"}, 32'(n_strobe - s0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, t1, r0;
        logic [7:0] exp_b [4];
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_we = 1'b0; req_ctrl = 3'd0;

        // Reset state
        #23;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_rsp",   {31'd0, rsp_valid}, 32'd0);
        check("rst_strb",  {22'd0, mem_we, mem_re, mem_addr, 1'b0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // SW 0x10 = 0xDEADBEEF: four write beats at t+1..t+4
        w0 = wr_addr.size();
        run("sw10", 32'h10, 32'hDEAD_BEEF, 1'b1, 3'b010, 5, 1'b0, 32'd0);
        check("sw10_nwr", 32'(wr_addr.size() - w0), 32'd4);
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        if (wr_addr.size() - w0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("sw10_cyc%0d", k), 32'(wr_cyc[w0+k] - t_acc), 32'(k + 1));
                check($sformatf("sw10_adr%0d", k), {24'd0, wr_addr[w0+k]}, 32'(8'h10 + k));
                check($sformatf("sw10_dat%0d", k), {24'd0, wr_data[w0+k]}, {24'd0, exp_b[k]});
            end
        end

        // Loads with each extension flavour
        run("lb13",  32'h13, 32'd0, 1'b0, 3'b000, 3, 1'b0, 32'hFFFF_FFDE);
        run("lbu13", 32'h13, 32'd0, 1'b0, 3'b100, 3, 1'b0, 32'h0000_00DE);
        run("lh12",  32'h12, 32'd0, 1'b0, 3'b001, 4, 1'b0, 32'hFFFF_DEAD);
        run("lhu12", 32'h12, 32'd0, 1'b0, 3'b101, 4, 1'b0, 32'h0000_DEAD);
        run("lh10",  32'h10, 32'd0, 1'b0, 3'b001, 4, 1'b0, 32'hFFFF_BEEF);
        run("lw10",  32'h10, 32'd0, 1'b0, 3'b010, 6, 1'b0, 32'hDEAD_BEEF);

        // Rejected requests
        run_err("lh11_misal", 32'h11, 1'b0, 3'b001);
        run_err("lw12_misal", 32'h12, 1'b0, 3'b010);
        run_err("ctrl011",    32'h10, 1'b0, 3'b011);
        run_err("ctrl111",    32'h10, 1'b0, 3'b111);
        run_err("sbu_store",  32'h10, 1'b1, 3'b100);
        run_err("lb80_oob",   32'h80, 1'b0, 3'b000);
        run_err("sw17c_oob",  32'h17C, 1'b1, 3'b010);
        run_err("lw7e_oob",   32'h7C + 32'h2, 1'b0, 3'b010);

        // Top byte of memory is legal
        run("sb7f", 32'h7F, 32'h0000_0085, 1'b1, 3'b000, 2, 1'b0, 32'd0);
        run("lb7f", 32'h7F, 32'd0, 1'b0, 3'b000, 3, 1'b0, 32'hFFFF_FF85);
        run("lw7c", 32'h7C, 32'd0, 1'b0, 3'b010, 6, 1'b0, 32'h8500_0000);

        // Back-to-back SB with req_valid held high
        w0 = wr_addr.size();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000_005A;
        req_we = 1'b1; req_ctrl = 3'b000;
        check("q_ready0", {31'd0, req_ready}, 32'd1);
        t1 = cyc;
        @(negedge clk);
        req_addr = 32'h31; req_wdata = 32'h0000_00A5;
        check("q_ready_t1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("q_rsp_t2",   {31'd0, rsp_valid}, 32'd1);
        check("q_ready_t2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("q_ready_t3", {31'd0, req_ready}, 32'd1);
        check("q_gap", 32'(cyc - t1), 32'd3);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("q_second", 2, 1'b0, 32'd0);
        check("q_nwr", 32'(wr_addr.size() - w0), 32'd2);
        run("q_lhu30", 32'h30, 32'd0, 1'b0, 3'b101, 4, 1'b0, 32'h0000_A55A);

        // Reset during beat 2 of SW 0x20
        w0 = wr_addr.size();
        start_req(32'h20, 32'h1122_3344, 1'b1, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        r0 = n_rsp;
        #1;
        check("ra_we",    {31'd0, mem_we}, 32'd0);
        check("ra_addr",  {25'd0, mem_addr}, 32'd0);
        check("ra_wdata", {24'd0, mem_wdata}, 32'd0);
        check("ra_busy",  {31'd0, busy}, 32'd0);
        check("ra_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ra_ready_after", {31'd0, req_ready}, 32'd1);
        check("ra_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("ra_nwr", 32'(wr_addr.size() - w0), 32'd2);
        run("ra_lw20", 32'h20, 32'd0, 1'b0, 3'b010, 6, 1'b0, 32'h0000_3344);

        @(negedge clk);
        check("strobe_rules", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
